// File: rtl/stall_fwd_ctrl_if.sv
// D-stage decode in, hazard decisions out, between the decoder/datapath and stall_fwd_ctrl.
// The master side drives the decoded D instruction; the slave side returns stall, forward selects and md_busy.
interface stall_fwd_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [2:0] D_rs_tuse;
  logic [2:0] D_rt_tuse;
  logic [4:0] D_waddr;
  logic [2:0] D_tnew;
  logic [1:0] D_md_op;

  logic       stall;
  logic [1:0] D_fwd_rs;
  logic [1:0] D_fwd_rt;
  logic [1:0] E_fwd_rs;
  logic [1:0] E_fwd_rt;
  logic       md_busy;

  modport master (
    output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_waddr, D_tnew, D_md_op,
    input  stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_waddr, D_tnew, D_md_op,
    output stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy
  );
endinterface

// File: rtl/stall_fwd_ctrl.sv
// Stall/forward controller for the five-stage MIPS pipeline: shadow E/M/W destination tracking
// with Tnew countdown, Tuse-based stall decision, forward selection and the mult/div busy counter.
module stall_fwd_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  stall_fwd_ctrl_if.slave bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_e;

  // E-stage shadow of the instruction that left D
  logic [4:0]    e_addr_q, e_addr_d;
  logic [2:0]    e_tnew_q, e_tnew_d;
  logic [4:0]    e_rs_q, e_rs_d;
  logic [4:0]    e_rt_q, e_rt_d;
  logic [2:0]    e_rs_tuse_q, e_rs_tuse_d;
  logic [2:0]    e_rt_tuse_q, e_rt_tuse_d;
  md_op_e        e_md_q, e_md_d;

  logic [4:0]    m_addr_q;
  logic [2:0]    m_tnew_q;
  logic [4:0]    w_addr_q;

  logic [CW-1:0] md_cnt_q, md_cnt_d;

  logic          md_busy;
  logic          data_stall;
  logic          md_stall;
  logic          stall;
  md_op_e        d_md_op;

  function automatic logic [2:0] dec_sat(input logic [2:0] x);
    return (x == 3'd0) ? 3'd0 : x - 3'd1;
  endfunction

  function automatic logic hazard(input logic [4:0] src, input logic [2:0] tuse,
                                  input logic [4:0] ea, input logic [2:0] et,
                                  input logic [4:0] ma, input logic [2:0] mt);
    logic hit;
    hit = 1'b0;
    if (src != 5'd0) begin
      if ((ea == src) && (et > tuse)) hit = 1'b1;
      if ((ma == src) && (mt > tuse)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Youngest producer that already has its result wins
  function automatic fwd_e sel_d(input logic [4:0] src,
                                 input logic [4:0] ea, input logic [2:0] et,
                                 input logic [4:0] ma, input logic [2:0] mt,
                                 input logic [4:0] wa);
    fwd_e sel;
    sel = FWD_REG;
    if (src != 5'd0) begin
      if ((ea == src) && (et == 3'd0))      sel = FWD_E;
      else if ((ma == src) && (mt == 3'd0)) sel = FWD_M;
      else if (wa == src)                   sel = FWD_W;
    end
    return sel;
  endfunction

  function automatic fwd_e sel_e(input logic [4:0] src,
                                 input logic [4:0] ma, input logic [2:0] mt,
                                 input logic [4:0] wa);
    fwd_e sel;
    sel = FWD_REG;
    if (src != 5'd0) begin
      if ((ma == src) && (mt == 3'd0)) sel = FWD_M;
      else if (wa == src)              sel = FWD_W;
    end
    return sel;
  endfunction

  assign d_md_op = md_op_e'(bus.D_md_op);
  assign md_busy = (md_cnt_q != '0);

  always_comb begin
    data_stall = hazard(bus.D_rs, bus.D_rs_tuse, e_addr_q, e_tnew_q, m_addr_q, m_tnew_q)
               | hazard(bus.D_rt, bus.D_rt_tuse, e_addr_q, e_tnew_q, m_addr_q, m_tnew_q);
    md_stall   = (d_md_op != MD_NONE) && (md_busy || (e_md_q != MD_NONE));
    stall      = data_stall | md_stall;
  end

  always_comb begin
    bus.stall    = stall;
    bus.md_busy  = md_busy;
    bus.D_fwd_rs = sel_d(bus.D_rs, e_addr_q, e_tnew_q, m_addr_q, m_tnew_q, w_addr_q);
    bus.D_fwd_rt = sel_d(bus.D_rt, e_addr_q, e_tnew_q, m_addr_q, m_tnew_q, w_addr_q);
    bus.E_fwd_rs = sel_e(e_rs_q, m_addr_q, m_tnew_q, w_addr_q);
    bus.E_fwd_rt = sel_e(e_rt_q, m_addr_q, m_tnew_q, w_addr_q);
  end

  // A stalled D instruction leaves a bubble behind in E
  always_comb begin
    e_addr_d    = 5'd0;
    e_tnew_d    = 3'd0;
    e_rs_d      = 5'd0;
    e_rt_d      = 5'd0;
    e_rs_tuse_d = 3'd0;
    e_rt_tuse_d = 3'd0;
    e_md_d      = MD_NONE;
    if (!stall) begin
      e_addr_d    = bus.D_waddr;
      e_tnew_d    = bus.D_tnew;
      e_rs_d      = bus.D_rs;
      e_rt_d      = bus.D_rt;
      e_rs_tuse_d = bus.D_rs_tuse;
      e_rt_tuse_d = bus.D_rt_tuse;
      if ((d_md_op == MD_MULT) || (d_md_op == MD_DIV)) e_md_d = d_md_op;
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_q == MD_MULT)      md_cnt_d = MULT_LD;
    else if (e_md_q == MD_DIV)  md_cnt_d = DIV_LD;
    else if (md_cnt_q != '0)    md_cnt_d = md_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_addr_q    <= 5'd0;
      e_tnew_q    <= 3'd0;
      e_rs_q      <= 5'd0;
      e_rt_q      <= 5'd0;
      e_rs_tuse_q <= 3'd0;
      e_rt_tuse_q <= 3'd0;
      e_md_q      <= MD_NONE;
      m_addr_q    <= 5'd0;
      m_tnew_q    <= 3'd0;
      w_addr_q    <= 5'd0;
      md_cnt_q    <= '0;
    end else begin
      e_addr_q    <= e_addr_d;
      e_tnew_q    <= e_tnew_d;
      e_rs_q      <= e_rs_d;
      e_rt_q      <= e_rt_d;
      e_rs_tuse_q <= e_rs_tuse_d;
      e_rt_tuse_q <= e_rt_tuse_d;
      e_md_q      <= e_md_d;
      m_addr_q    <= e_addr_q;
      m_tnew_q    <= dec_sat(e_tnew_q);
      w_addr_q    <= m_addr_q;
      md_cnt_q    <= md_cnt_d;
    end
  end

  // Operand Tuse of the E instruction is carried for debug visibility of the shadow pipe
  logic unused_tuse;
  assign unused_tuse = ^{e_rs_tuse_q, e_rt_tuse_q};

endmodule

// File: tb/tb_stall_fwd_ctrl.sv
// Directed bench for stall_fwd_ctrl: each vector pushes its hand-computed expectation into a
// queue, and a negedge monitor pops and compares against the DUT outputs.
module tb_stall_fwd_ctrl;

  logic clk;
  logic reset;

  stall_fwd_ctrl_if bus ();

  stall_fwd_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    st;
    int    dfs;
    int    dft;
    int    efs;
    int    eft;
    int    busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string field, input int act, input int expv);
    if (expv >= 0) begin
      checks++;
      if (act != expv) begin
        errors++;
        $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", nm, field, act, expv, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "stall",    int'(bus.stall),    e.st);
      chk(e.nm, "D_fwd_rs", int'(bus.D_fwd_rs), e.dfs);
      chk(e.nm, "D_fwd_rt", int'(bus.D_fwd_rt), e.dft);
      chk(e.nm, "E_fwd_rs", int'(bus.E_fwd_rs), e.efs);
      chk(e.nm, "E_fwd_rt", int'(bus.E_fwd_rt), e.eft);
      chk(e.nm, "md_busy",  int'(bus.md_busy),  e.busy);
    end
  end

  // One D-stage cycle: drive just after the rising edge, expectation checked at the falling edge
  task automatic vec(input string nm, input logic rb,
                     input int rs, input int rt, input int rst, input int rtt,
                     input int wa, input int tn, input int md,
                     input int st, input int dfs, input int dft,
                     input int efs, input int eft, input int busy);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rb;
    bus.D_rs      = 5'(rs);
    bus.D_rt      = 5'(rt);
    bus.D_rs_tuse = 3'(rst);
    bus.D_rt_tuse = 3'(rtt);
    bus.D_waddr   = 5'(wa);
    bus.D_tnew    = 3'(tn);
    bus.D_md_op   = 2'(md);
    e.nm = nm; e.st = st; e.dfs = dfs; e.dft = dft; e.efs = efs; e.eft = eft; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic nop(input string nm, input int efs, input int eft);
    vec(nm, 1'b1, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, efs, eft, 0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.D_rs      = 5'd8;
    bus.D_rt      = 5'd9;
    bus.D_rs_tuse = 3'd0;
    bus.D_rt_tuse = 3'd0;
    bus.D_waddr   = 5'd8;
    bus.D_tnew    = 3'd2;
    bus.D_md_op   = 2'd3;

    // reset held with busy-looking inputs
    vec("rst_hold", 1'b0, 8, 9, 0, 0, 8, 2, 3, 0, 0, 0, 0, 0, 0);
    nop("rst_rel", 0, 0);

    // load-use: lw r8 (tnew 2) then rs=8 tuse 1
    vec("lw",       1'b1, 0, 0, 7, 7, 8, 2, 0, 0, 0, 0, 0, 0, 0);
    vec("lu_c1",    1'b1, 8, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vec("lu_c2",    1'b1, 8, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("lu_c3",    1'b1, 8, 0, 1, 7, 0, 0, 0, 0, 3, 0, 3, 0, 0);
    nop("lu_n1", 0, 0);
    nop("lu_n2", 0, 0);

    // ALU then beq with tuse 0: one stall, then forward from M
    vec("add0",     1'b1, 0, 0, 7, 7, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    vec("beq_c1",   1'b1, 9, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vec("beq_c2",   1'b1, 9, 0, 0, 7, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    nop("beq_n1", 3, 0);
    nop("beq_n2", 0, 0);

    // ALU then consumer with tuse 1: no stall, E-stage forward from M
    vec("add1",     1'b1, 0, 0, 7, 7, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    vec("use_c1",   1'b1, 9, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("use_n1", 2, 0);
    nop("use_n2", 0, 0);

    // $0 never stalls or forwards
    vec("w0",       1'b1, 0, 0, 7, 7, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    vec("r0",       1'b1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("r0_n1", 0, 0);

    // r5 produced in both E and M with tnew 0: E wins
    vec("p_m",      1'b1, 0, 0, 7, 7, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("p_e",      1'b1, 0, 0, 7, 7, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    vec("p_use",    1'b1, 0, 5, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    nop("p_n1", 0, 2);
    nop("p_n2", 0, 0);

    // div then mfhi
    vec("div",      1'b1, 0, 0, 7, 7, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    vec("dv_e",     1'b1, 0, 0, 7, 7, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      vec($sformatf("dv_busy%0d", i), 1'b1, 0, 0, 7, 7, 0, 0, 3, 1, 0, 0, 0, 0, 1);
    vec("dv_issue", 1'b1, 0, 0, 7, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    nop("dv_n1", 0, 0);

    // mult then mfhi
    vec("mult",     1'b1, 0, 0, 7, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vec("mu_e",     1'b1, 0, 0, 7, 7, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      vec($sformatf("mu_busy%0d", i), 1'b1, 0, 0, 7, 7, 0, 0, 3, 1, 0, 0, 0, 0, 1);
    vec("mu_issue", 1'b1, 0, 0, 7, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    nop("mu_n1", 0, 0);

    // reset asserted between edges while the divider is busy
    vec("rd_div",   1'b1, 0, 0, 7, 7, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    vec("rd_e",     1'b1, 0, 0, 7, 7, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    vec("rd_busy",  1'b1, 0, 0, 7, 7, 0, 0, 3, 1, 0, 0, 0, 0, 1);
    vec("rst_mid",  1'b0, 5, 5, 0, 0, 5, 3, 3, 0, 0, 0, 0, 0, 0);
    vec("rst_post", 1'b1, 0, 0, 7, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    nop("rst_n1", 0, 0);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stall_fwd_ctrl.md
# stall_fwd_ctrl

Hazard controller that consumes the per-instruction decode of the D-stage control decoder (register addresses, Tuse and Tnew codes) and decides stall and forwarding for the five-stage MIPS pipeline. It keeps a shadow pipeline of E/M/W destination registers and their remaining Tnew, counting them down each cycle. It also runs the multiply/divide busy counter. It sits between the D-stage decoder and the pipeline-register enables and forwarding muxes of the datapath.

## Interface
- MULT_CYCLES, 5, E-stage busy cycles after a mult/multu start
- DIV_CYCLES, 10, E-stage busy cycles after a div/divu start
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low; clears all tracking state
- D_rs, D_rt  input  5 each  source registers of the D instruction
- D_rs_tuse, D_rt_tuse  input  3 each  cycles from D until the operand is needed (7 = unused)
- D_waddr  input  5  destination register (0 = none)
- D_tnew  input  3  cycles from E entry until the result is produced
- D_md_op  input  2  0 none, 1 mult start, 2 div start, 3 reads/writes HI/LO
- stall  output  1  freeze PC and the F/D register, inject a bubble into E
- D_fwd_rs, D_fwd_rt  output  2 each  D operand source: 0 GRF, 1 E, 2 M, 3 W
- E_fwd_rs, E_fwd_rt  output  2 each  E operand source: 0 register value, 2 M, 3 W
- md_busy  output  1  multiply/divide unit is running

## Operation
- Tracker per stage E, M and W: addr[4:0] and tnew[2:0]. E also holds rs, rt, rs_tuse, rt_tuse and md_start.
- Each clock, not stalled:
  - E is loaded from the D inputs.
  - M.addr = E.addr and M.tnew = sat(E.tnew − 1).
  - W.addr = M.addr and W.tnew = 0.
- Each clock, stalled: E is loaded with a bubble (all fields 0, md_start 0). M and W advance as above.
- sat(x − 1) clamps at 0. The 3-bit subtract never wraps.
- Data stall for src in {rs, rt}, with src ≠ 0:
  - (E.addr == src and E.tnew > src_tuse), or
  - (M.addr == src and M.tnew > src_tuse).
- MD stall: D_md_op ≠ 0 and (md_busy or E.md_start).
- stall = OR of the data stall and the MD stall.
- D forward priority, for src ≠ 0 and tnew == 0: E (1) > M (2) > W (3). Otherwise 0. Address 0 never forwards.
- E forward uses the E-held rs and rt with the same rule: M (2) > W (3) > 0.
- MD counter:
  - Loads MULT_CYCLES or DIV_CYCLES when E.md_start is 1 (1 = mult, 2 = div), then decrements to 0.
  - md_busy = (counter ≠ 0).
  - A new start while busy is impossible, because the MD stall holds it in D.
- Reset mid-operation: all trackers, E fields and the counter go to 0 immediately, regardless of clk.

## Timing
- Reset values:
  - stall = 0, md_busy = 0.
  - All fwd outputs = 0.
  - All trackers = 0.
- stall and the fwd outputs are combinational from the D inputs and registered state, valid in the same cycle.
- Tracker update latency is 1 cycle. The stall decision made in cycle n produces the bubble in E at edge n+1.
- Simultaneous match in E and M on the same register: E wins for forwarding. A stall from either stage stalls.
- md_busy rises 1 cycle after the start instruction leaves E.
- md_busy stays high exactly MULT_CYCLES or DIV_CYCLES cycles.
- W tnew is always 0. W never causes a stall.

## Test plan
- Reset with reset = 0 during arbitrary inputs -> stall = 0, md_busy = 0, all fwd = 0, even if it asserts between clock edges.
- Load-use hazard:
  - Cycle 0: lw, D_waddr = 8, D_tnew = 2.
  - Cycle 1: D_rs = 8, rs_tuse = 1.
  - Required: stall = 1 in cycle 1, stall = 0 in cycle 2, D_fwd_rs = 3 (W) in cycle 3.
- ALU back-to-back:
  - add, waddr = 9, tnew = 1, then beq with D_rs = 9, tuse = 0 -> stall for 1 cycle, then D_fwd_rs = 2.
  - The same case with tuse = 1 -> no stall, E_fwd_rs = 2 next cycle.
- Register $0: waddr = 0, tnew = 2, then D_rs = 0 -> stall = 0, D_fwd_rs = 0.
- Priority: E.addr = M.addr = 5, both tnew 0, D_rt = 5 -> D_fwd_rt = 1.
- MD:
  - div start followed by mfhi (D_md_op = 3) -> stall while E.md_start or md_busy.
  - md_busy high for exactly 10 cycles; mfhi issues on the cycle md_busy falls.
  - Repeat with mult: 5 cycles.
